// File: rtl/wb_mux_pkg.sv
// Shared definitions for the Wishbone peripheral interconnect:
// transaction FSM encoding, default error read data and the slot-index helper.
package wb_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Widest slot index the helper can return; callers truncate to their own width.
  localparam int SLOT_MAX_W = 16;

  // Slot index of an address: the bits starting at lsb.
  function automatic logic [SLOT_MAX_W-1:0] slot_idx(input logic [31:0] adr, input int lsb);
    return SLOT_MAX_W'(adr >> lsb);
  endfunction

endpackage

// File: rtl/wb_periph_mux_if.sv
// Caravel user-area Wishbone port as seen by the peripheral interconnect.
// The master modport is the Caravel side; the slave modport is the interconnect.
interface wb_periph_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_err_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_err_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mux_timeout.sv
// Slave-hang watchdog: cleared when a transaction enters BUSY, counts every
// BUSY cycle and flags expiry once TIMEOUT cycles have gone by without an ack.
// Only instantiated when WBMUX_TIMEOUT_EN is defined.
module wb_mux_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expire = count && (cnt == CW'(TIMEOUT));

  // Cycle counter: clear on BUSY entry, advance while BUSY, hold at expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_periph_mux.sv
// Wishbone peripheral interconnect: decodes one 4 KB slot per slave, strobes
// the selected slave, registers its data/ack back to the master, and answers
// unmapped (or, with WBMUX_TIMEOUT_EN defined, hung) accesses with an error
// termination while recording the error count and address.
module wb_periph_mux
  import wb_mux_pkg::*;
#(
  parameter int          NSLV     = 5,
  parameter int          SEL_LSB  = 12,
  parameter int          SW       = 4,
  parameter logic [31:0] BASE_TAG = 32'h0000_3000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_periph_mux_if.slave       bus,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [32*NSLV-1:0]   s_dat_i,
  output logic [7:0]           err_cnt_o,
  output logic [31:0]          err_addr_o
);

  state_t        state;
  logic [SW-1:0] slot_q;
  logic [31:0]   adr_q;
  logic          ack_q;
  logic          err_q;
  logic [31:0]   dat_q;
  logic [7:0]    err_cnt_q;
  logic [31:0]   err_addr_q;

  logic          req;
  logic [SW-1:0] slot_d;
  logic          mapped;
  logic          sel_ack;
  logic [31:0]   sel_dat;
  logic          timeout_hit;
  logic          err_take;
  logic [31:0]   err_adr_src;
  logic          unused_bus;

  assign req    = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign slot_d = SW'(slot_idx(bus.wbs_adr_i, SEL_LSB));
  assign mapped = ((bus.wbs_adr_i >> (SEL_LSB + SW)) == BASE_TAG) && (int'(slot_d) < NSLV);

  // Write enable, byte selects and write data reach the slaves straight off the bus.
  assign unused_bus = ^{bus.wbs_we_i, bus.wbs_sel_i, bus.wbs_dat_i};

  // Route the latched slot: its strobe out, its ack and read data back.
  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    s_stb_o = '0;
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (slot_q == SW'(k)) begin
        s_stb_o[k] = (state == ST_BUSY) && req;
        sel_ack    = s_ack_i[k];
        sel_dat    = s_dat_i[32*k +: 32];
      end
    end
  end

`ifdef WBMUX_TIMEOUT_EN
  logic to_load;
  logic to_count;

  assign to_load  = (state == ST_IDLE) && req && mapped;
  assign to_count = (state == ST_BUSY);

  wb_mux_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .load   (to_load),
    .count  (to_count),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // An error ends either an unmapped request in IDLE or a hung slave in BUSY;
  // a slave ack in the same cycle beats the timeout.
  assign err_take = ((state == ST_IDLE) && req && !mapped) ||
                    ((state == ST_BUSY) && bus.wbs_cyc_i && !sel_ack && timeout_hit);
  assign err_adr_src = (state == ST_IDLE) ? bus.wbs_adr_i : adr_q;

  // Transaction FSM with registered ack/err/data and error capture.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= ST_IDLE;
      slot_q     <= '0;
      adr_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req && mapped) begin
            slot_q <= slot_d;
            adr_q  <= bus.wbs_adr_i;
            state  <= ST_BUSY;
          end else if (req) begin
            state <= ST_ERR;
          end
        end
        ST_BUSY: begin
          if (!bus.wbs_cyc_i) begin
            state <= ST_IDLE;
          end else if (sel_ack) begin
            dat_q <= sel_dat;
            ack_q <= 1'b1;
            state <= ST_RESP;
          end else if (timeout_hit) begin
            state <= ST_ERR;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (err_take) begin
        ack_q      <= 1'b1;
        err_q      <= 1'b1;
        dat_q      <= ERR_DATA;
        err_addr_q <= err_adr_src;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_err_o = err_q;
  assign bus.wbs_dat_o = dat_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_wb_periph_mux.sv
// Directed bench for wb_periph_mux (NSLV=5, TIMEOUT=8): reads, writes,
// unmapped errors, back-to-back requests, hang handling, abort/reset and
// error-counter saturation, each with hand-computed expectations.
module tb_wb_periph_mux;
  localparam int NSLV = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NSLV-1:0]     s_stb;
  logic [NSLV-1:0]     s_ack;
  logic [32*NSLV-1:0]  s_dat;
  logic [7:0]          err_cnt;
  logic [31:0]         err_addr;

  int total = 0;
  int bad   = 0;

  wb_periph_mux_if bus ();

  wb_periph_mux #(
    .NSLV    (NSLV),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .bus        (bus),
    .s_stb_o    (s_stb),
    .s_ack_i    (s_ack),
    .s_dat_i    (s_dat),
    .err_cnt_o  (err_cnt),
    .err_addr_o (err_addr)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] adr, input logic we);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = 32'hA5A5_0000 ^ adr;
  endtask

  task automatic drop_req();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drop_req();
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    s_ack = '0;
    s_dat = '0;
    tick();
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, s_stb} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {bus.wbs_ack_o, bus.wbs_err_o, s_stb});
    end
    total++;
    if ({bus.wbs_dat_o, err_cnt, err_addr} !== 72'h0) begin
      bad++; $display("FAIL reset_regs got dat=%h cnt=%0d addr=%h want all 0", bus.wbs_dat_o, err_cnt, err_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    start_req(32'h3000_2004, 1'b0);
    s_dat[32*0 +: 32] = 32'hBAD0_0000;
    s_dat[32*2 +: 32] = 32'hFFFF_FFFF;
    tick();                              // BUSY
    total++;
    if ({s_stb, bus.wbs_ack_o} !== {5'b00100, 1'b0}) begin
      bad++; $display("FAIL rd_busy1 got stb=%b ack=%b want stb=00100 ack=0", s_stb, bus.wbs_ack_o);
    end
    s_ack[0] = 1'b1;                     // stray ack from an unselected slave
    tick();
    total++;
    if ({s_stb, bus.wbs_ack_o} !== {5'b00100, 1'b0}) begin
      bad++; $display("FAIL rd_ignore_other_ack got stb=%b ack=%b want stb=00100 ack=0", s_stb, bus.wbs_ack_o);
    end
    s_ack = 5'b00100;
    s_dat[32*2 +: 32] = 32'h1234_5678;
    tick();                              // RESP
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== {2'b10, 32'h1234_5678}) begin
      bad++; $display("FAIL rd_resp got ack=%b err=%b dat=%h want ack=1 err=0 dat=12345678", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o);
    end
    drop_req();
    s_ack = '0;
    tick();
    total++;
    if ({bus.wbs_ack_o, s_stb} !== 6'b0) begin
      bad++; $display("FAIL rd_after got ack=%b stb=%b want 0", bus.wbs_ack_o, s_stb);
    end
  endtask

  task automatic test_write();
    int acks = 0;
    start_req(32'h3000_0010, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({s_stb, bus.wbs_ack_o} !== {5'b00001, 1'b0}) begin
        bad++; $display("FAIL wr_hold%0d got stb=%b ack=%b want stb=00001 ack=0", c, s_stb, bus.wbs_ack_o);
      end
      tick();
    end
    s_ack = 5'b00001;
    tick();
    if (bus.wbs_ack_o === 1'b1) acks++;
    drop_req();
    s_ack = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) acks++;
    end
    total++;
    if (acks !== 1) begin
      bad++; $display("FAIL wr_ack_pulses got=%0d want=1", acks);
    end
  endtask

  task automatic test_unmapped();
    start_req(32'h3000_7000, 1'b0);
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr, s_stb} !==
        {2'b11, 32'hDEAD_BEEF, 8'd1, 32'h3000_7000, 5'b0}) begin
      bad++; $display("FAIL unm_slot7 got ack=%b err=%b dat=%h cnt=%0d addr=%h stb=%b", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr, s_stb);
    end
    drop_req();
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o} !== 2'b00) begin
      bad++; $display("FAIL unm_pulse got ack=%b err=%b want 00", bus.wbs_ack_o, bus.wbs_err_o);
    end
    start_req(32'h3100_0000, 1'b0);
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr} !==
        {2'b11, 32'hDEAD_BEEF, 8'd2, 32'h3100_0000}) begin
      bad++; $display("FAIL unm_tag got ack=%b err=%b dat=%h cnt=%0d addr=%h", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr);
    end
    drop_req();
    tick();
  endtask

  task automatic test_back_to_back();
    // Request held on an unmapped address: error, idle re-sample, error again.
    start_req(32'h3000_5000, 1'b0);
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, err_cnt} !== {2'b11, 8'd3}) begin
      bad++; $display("FAIL b2b_first got ack=%b err=%b cnt=%0d want 1 1 3", bus.wbs_ack_o, bus.wbs_err_o, err_cnt);
    end
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, err_cnt} !== {2'b00, 8'd3}) begin
      bad++; $display("FAIL b2b_gap got ack=%b err=%b cnt=%0d want 0 0 3", bus.wbs_ack_o, bus.wbs_err_o, err_cnt);
    end
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, err_cnt} !== {2'b11, 8'd4}) begin
      bad++; $display("FAIL b2b_second got ack=%b err=%b cnt=%0d want 1 1 4", bus.wbs_ack_o, bus.wbs_err_o, err_cnt);
    end
    drop_req();
    tick();
    // Highest mapped slot (4) with the slave acking in its first strobe cycle.
    start_req(32'h3000_4ABC, 1'b0);
    tick();
    total++;
    if (s_stb !== 5'b10000) begin
      bad++; $display("FAIL slot4_stb got=%b want=10000", s_stb);
    end
    s_ack = 5'b10000;
    s_dat[32*4 +: 32] = 32'hCAFE_0004;
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== {2'b10, 32'hCAFE_0004}) begin
      bad++; $display("FAIL slot4_resp got ack=%b err=%b dat=%h want 1 0 cafe0004", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o);
    end
    drop_req();
    s_ack = '0;
    tick();
  endtask

`ifdef WBMUX_TIMEOUT_EN
  task automatic test_timeout();
    start_req(32'h3000_1ABC, 1'b0);
    tick();                              // BUSY entry
    for (int c = 1; c <= 8; c++) begin
      tick();
      total++;
      if ({s_stb, bus.wbs_ack_o} !== {5'b00010, 1'b0}) begin
        bad++; $display("FAIL to_wait%0d got stb=%b ack=%b want stb=00010 ack=0", c, s_stb, bus.wbs_ack_o);
      end
    end
    tick();                              // 9th edge after entry: error
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr, s_stb} !==
        {2'b11, 32'hDEAD_BEEF, 8'd5, 32'h3000_1ABC, 5'b0}) begin
      bad++; $display("FAIL to_expire got ack=%b err=%b dat=%h cnt=%0d addr=%h stb=%b", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt, err_addr, s_stb);
    end
    drop_req();
    tick();
  endtask
`else
  task automatic test_timeout();
    start_req(32'h3000_1ABC, 1'b0);
    tick();
    for (int c = 1; c <= 20; c++) begin
      tick();
      total++;
      if ({s_stb, bus.wbs_ack_o} !== {5'b00010, 1'b0}) begin
        bad++; $display("FAIL nto_wait%0d got stb=%b ack=%b want stb=00010 ack=0", c, s_stb, bus.wbs_ack_o);
      end
    end
    s_ack = 5'b00010;
    s_dat[32*1 +: 32] = 32'h1111_0001;
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt} !== {2'b10, 32'h1111_0001, 8'd4}) begin
      bad++; $display("FAIL nto_resp got ack=%b err=%b dat=%h cnt=%0d", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, err_cnt);
    end
    drop_req();
    s_ack = '0;
    tick();
  endtask
`endif

  task automatic test_abort_reset();
    int acks = 0;
    start_req(32'h3000_3000, 1'b0);
    tick();
    total++;
    if (s_stb !== 5'b01000) begin
      bad++; $display("FAIL abort_stb got=%b want=01000", s_stb);
    end
    bus.wbs_cyc_i = 1'b0;
    #1;
    total++;
    if (s_stb !== 5'b00000) begin
      bad++; $display("FAIL abort_stb_drop got=%b want=00000", s_stb);
    end
    s_ack = 5'b01000;                    // late ack after the abort
    tick();
    if (bus.wbs_ack_o === 1'b1) acks++;
    tick();
    if (bus.wbs_ack_o === 1'b1) acks++;
    drop_req();
    s_ack = '0;
    total++;
    if (acks !== 0) begin
      bad++; $display("FAIL abort_no_ack got=%0d want=0", acks);
    end
    // Reset pulse in BUSY while the slave acks.
    start_req(32'h3000_3000, 1'b0);
    tick();
    rst_n = 1'b0;
    s_ack = 5'b01000;
    s_dat[32*3 +: 32] = 32'h7777_7777;
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, s_stb, err_cnt, err_addr} !== 79'h0) begin
      bad++; $display("FAIL rst_mid got ack=%b err=%b dat=%h stb=%b cnt=%0d addr=%h want all 0", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o, s_stb, err_cnt, err_addr);
    end
    rst_n = 1'b1;
    drop_req();
    s_ack = '0;
    tick();
    total++;
    if (bus.wbs_ack_o !== 1'b0) begin
      bad++; $display("FAIL rst_no_ack got=%b want=0", bus.wbs_ack_o);
    end
    start_req(32'h3000_3010, 1'b0);
    tick();
    s_ack = 5'b01000;
    s_dat[32*3 +: 32] = 32'h5A5A_0003;
    tick();
    total++;
    if ({bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o} !== {2'b10, 32'h5A5A_0003}) begin
      bad++; $display("FAIL rst_recover got ack=%b err=%b dat=%h want 1 0 5a5a0003", bus.wbs_ack_o, bus.wbs_err_o, bus.wbs_dat_o);
    end
    drop_req();
    s_ack = '0;
    tick();
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 300; i++) begin
      start_req(32'h3000_8000 + 32'(i), 1'b0);
      tick();                            // ERR: error number i recorded
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        total++;
        if (err_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          bad++; $display("FAIL sat_cnt_at%0d got=%0d want=%0d", i, err_cnt, (i > 255) ? 255 : i);
        end
      end
      tick();                            // back to IDLE
    end
    drop_req();
    tick();
    total++;
    if ({err_cnt, err_addr} !== {8'd255, 32'h3000_812C}) begin
      bad++; $display("FAIL sat_final got cnt=%0d addr=%h want 255 3000812c", err_cnt, err_addr);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_back_to_back();
    test_timeout();
    test_abort_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
